// File: rtl/irq_source.sv
// Interrupt-pending source: 64-bit mtime/mtimecmp timer, software interrupt bit and
// synchronized external IRQ lines, all presented as registered pending bits.
module irq_source #(
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EXT_EDGE    = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic [2:0]  ext_irq_in,
  input  logic        irq_ack,
  input  logic [3:0]  ack_cause,
  output logic        msip,
  output logic        mtip,
  output logic        meip,
  output logic        seip,
  output logic        ueip
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [63:0]                   mtime_q, mtime_d;
  logic [63:0]                   mtimecmp_q, mtimecmp_d;
  logic                          msip_q, msip_d;
  logic                          mtip_q, mtip_d;
  logic [SYNC_STAGES-1:0][2:0]   sync_q, sync_d;
  logic [2:0]                    s_prev_q;
  logic [2:0]                    pend_q, pend_d;
  logic [2:0]                    sync_s;
  logic [2:0]                    clr;
  logic                          tick;

  assign tick   = (cnt_q == CntW'(PRESCALE - 1));
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CntW'(1);
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en) begin
      case (wr_addr)
        // A half-word write replaces the increment; the other half is held without carry.
        3'd0: begin
          mtime_d = {mtime_q[63:32], wr_data};
          cnt_d   = '0;
        end
        3'd1: begin
          mtime_d = {wr_data, mtime_q[31:0]};
          cnt_d   = '0;
        end
        3'd2: mtimecmp_d = {mtimecmp_q[63:32], wr_data};
        3'd3: mtimecmp_d = {wr_data, mtimecmp_q[31:0]};
        3'd4: msip_d = wr_data[0];
        default: ;
      endcase
    end
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = ext_irq_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    clr    = '0;
    clr[2] = irq_ack && (ack_cause == 4'd11);
    clr[1] = irq_ack && (ack_cause == 4'd9);
    clr[0] = irq_ack && (ack_cause == 4'd8);
    // A fresh edge wins over a same-cycle acknowledge.
    if (EXT_EDGE) begin
      pend_d = (sync_s & ~s_prev_q) | (pend_q & ~clr);
    end else begin
      pend_d = sync_s;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      sync_q     <= '0;
      s_prev_q   <= '0;
      pend_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      sync_q     <= sync_d;
      s_prev_q   <= sync_s;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      3'd0:    rd_data = mtime_q[31:0];
      3'd1:    rd_data = mtime_q[63:32];
      3'd2:    rd_data = mtimecmp_q[31:0];
      3'd3:    rd_data = mtimecmp_q[63:32];
      3'd4:    rd_data = {31'd0, msip_q};
      default: rd_data = '0;
    endcase
  end

  assign msip = msip_q;
  assign mtip = mtip_q;
  assign meip = pend_q[2];
  assign seip = pend_q[1];
  assign ueip = pend_q[0];

endmodule

// File: tb/tb_irq_source.sv
// Randomized bench for irq_source: two instances (edge mode / PRESCALE=1 and level mode /
// PRESCALE=4) share stimulus and are compared each cycle against a behavioural model.
module tb_irq_source;

  logic        clk_in = 1'b0;
  logic        reset_in, wr_en, irq_ack;
  logic [2:0]  wr_addr, rd_addr, ext_irq_in;
  logic [31:0] wr_data;
  logic [3:0]  ack_cause;
  logic [31:0] rd_a, rd_b;
  logic        msip_a, mtip_a, meip_a, seip_a, ueip_a;
  logic        msip_b, mtip_b, meip_b, seip_b, ueip_b;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  irq_source #(.PRESCALE(1), .SYNC_STAGES(2), .EXT_EDGE(1'b1)) dut_a (
    .clk_in(clk_in), .reset_in(reset_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_a), .ext_irq_in(ext_irq_in), .irq_ack(irq_ack),
    .ack_cause(ack_cause), .msip(msip_a), .mtip(mtip_a), .meip(meip_a), .seip(seip_a),
    .ueip(ueip_a)
  );

  irq_source #(.PRESCALE(4), .SYNC_STAGES(2), .EXT_EDGE(1'b0)) dut_b (
    .clk_in(clk_in), .reset_in(reset_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_b), .ext_irq_in(ext_irq_in), .irq_ack(irq_ack),
    .ack_cause(ack_cause), .msip(msip_b), .mtip(mtip_b), .meip(meip_b), .seip(seip_b),
    .ueip(ueip_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mtime = base + (edges since last reset/mtime write) / PRESCALE.
  logic [63:0] m_base [2];
  logic [63:0] m_cmp  [2];
  int unsigned m_n    [2];
  logic        m_msip [2];
  logic        m_mtip [2];
  logic [2:0]  m_pend [2];
  logic [2:0]  hist   [3];  // ext samples, [0] = most recent edge

  function automatic int unsigned ps_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] m_time(input int k);
    return m_base[k] + 64'(m_n[k] / ps_of(k));
  endfunction

  task automatic model_step();
    logic [2:0]  s, sp, clr;
    logic [63:0] t;
    s   = hist[1];
    sp  = hist[2];
    clr = '0;
    if (irq_ack) begin
      if (ack_cause == 4'd11) clr[2] = 1'b1;
      if (ack_cause == 4'd9)  clr[1] = 1'b1;
      if (ack_cause == 4'd8)  clr[0] = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (reset_in) begin
        m_base[k] = '0; m_n[k] = 0; m_cmp[k] = '1;
        m_msip[k] = 1'b0; m_mtip[k] = 1'b0; m_pend[k] = '0;
      end else begin
        t = m_time(k);
        m_mtip[k] = (t >= m_cmp[k]);
        if (k == 0) m_pend[k] = (s & ~sp) | (m_pend[k] & ~clr);
        else        m_pend[k] = s;
        if (wr_en && wr_addr == 3'd0) begin
          m_base[k] = {t[63:32], wr_data}; m_n[k] = 0;
        end else if (wr_en && wr_addr == 3'd1) begin
          m_base[k] = {wr_data, t[31:0]}; m_n[k] = 0;
        end else begin
          m_n[k]++;
        end
        if (wr_en && wr_addr == 3'd2) m_cmp[k][31:0]  = wr_data;
        if (wr_en && wr_addr == 3'd3) m_cmp[k][63:32] = wr_data;
        if (wr_en && wr_addr == 3'd4) m_msip[k] = wr_data[0];
      end
    end
    if (reset_in) begin
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
    end else begin
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = ext_irq_in;
    end
  endtask

  function automatic logic [31:0] m_rd(input int k, input logic [2:0] a);
    logic [63:0] t;
    t = m_time(k);
    case (a)
      3'd0:    return t[31:0];
      3'd1:    return t[63:32];
      3'd2:    return m_cmp[k][31:0];
      3'd3:    return m_cmp[k][63:32];
      3'd4:    return {31'd0, m_msip[k]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic compare_all();
    check_eq("a.msip", 64'(msip_a), 64'(m_msip[0]));
    check_eq("a.mtip", 64'(mtip_a), 64'(m_mtip[0]));
    check_eq("a.pend", 64'({meip_a, seip_a, ueip_a}), 64'(m_pend[0]));
    check_eq("a.rd",   64'(rd_a),   64'(m_rd(0, rd_addr)));
    check_eq("b.msip", 64'(msip_b), 64'(m_msip[1]));
    check_eq("b.mtip", 64'(mtip_b), 64'(m_mtip[1]));
    check_eq("b.pend", 64'({meip_b, seip_b, ueip_b}), 64'(m_pend[1]));
    check_eq("b.rd",   64'(rd_b),   64'(m_rd(1, rd_addr)));
  endtask

  // Inputs change only after the negedge compare; the model samples them right at the posedge.
  task automatic drive(input logic rst, input logic we, input logic [2:0] wa,
                       input logic [31:0] wd, input logic [2:0] ra, input logic [2:0] ext,
                       input logic ack, input logic [3:0] cause);
    reset_in = rst; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    ext_irq_in = ext; irq_ack = ack; ack_cause = cause;
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic idle(input int n, input logic [2:0] ra, input logic [2:0] ext);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 32'd0, ra, ext, 1'b0, 4'd0);
  endtask

  function automatic logic [31:0] rand_data(input logic [2:0] a);
    int unsigned r;
    r = $urandom_range(0, 7);
    if (a == 3'd1 || a == 3'd3) begin
      if (r < 5) return 32'd0;
      if (r < 7) return 32'hFFFF_FFFF;
      return $urandom;
    end
    if (r == 0) return 32'hFFFF_FFFF;
    return 32'($urandom_range(0, 60));
  endfunction

  initial begin
    logic [3:0]  causes [5];
    logic [2:0]  ext, wa;
    logic        we, ack, rst;
    causes[0] = 4'd8; causes[1] = 4'd9; causes[2] = 4'd11; causes[3] = 4'd3; causes[4] = 4'd7;

    // Reset state
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd2, 3'd0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd2, 3'd0, 1'b0, 4'd0);
    check_eq("rst_cmp_lo", 64'(rd_a), 64'h0000_0000_FFFF_FFFF);
    check_eq("rst_mtip", 64'(mtip_a), 64'd0);

    // Compare against 5
    drive(1'b0, 1'b1, 3'd3, 32'd0, 3'd0, 3'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'd2, 32'd5, 3'd0, 3'd0, 1'b0, 4'd0);
    idle(8, 3'd0, 3'd0);
    check_eq("mtip_set", 64'(mtip_a), 64'd1);

    // msip write/read, unmapped read
    drive(1'b0, 1'b1, 3'd4, 32'd1, 3'd4, 3'd0, 1'b0, 4'd0);
    check_eq("msip_rd1", 64'(rd_a), 64'd1);
    drive(1'b0, 1'b1, 3'd4, 32'd0, 3'd6, 3'd0, 1'b0, 4'd0);
    check_eq("msip_clr", 64'(msip_a), 64'd0);
    check_eq("rd_addr6", 64'(rd_a), 64'd0);

    // One-cycle pulse on machine line, then acks
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd4, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd0, 1'b0, 4'd0);
    check_eq("meip_early", 64'(meip_a), 64'd0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd0, 1'b0, 4'd0);
    check_eq("meip_3edge", 64'(meip_a), 64'd1);
    idle(3, 3'd1, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd0, 1'b1, 4'd9);
    check_eq("meip_ack9", 64'(meip_a), 64'd1);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd4, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd0, 1'b1, 4'd11);
    check_eq("meip_setwins", 64'(meip_a), 64'd1);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd0, 1'b1, 4'd11);
    check_eq("meip_ack11", 64'(meip_a), 64'd0);

    // mtime wrap
    drive(1'b0, 1'b1, 3'd2, 32'd10, 3'd0, 3'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 3'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 3'd1, 3'd0, 1'b0, 4'd0);
    check_eq("wrap_hi", 64'(rd_a), 64'h0000_0000_FFFF_FFFF);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd0, 1'b0, 4'd0);
    check_eq("wrap_zero", 64'(rd_a), 64'd0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0, 4'd0);
    check_eq("wrap_mtip", 64'(mtip_a), 64'd0);

    // Reset mid-count with a pending level interrupt on the PRESCALE=4 instance
    drive(1'b0, 1'b1, 3'd0, 32'd7, 3'd0, 3'd4, 1'b0, 4'd0);
    idle(2, 3'd0, 3'd4);
    check_eq("b_mtime7", 64'(rd_b), 64'd7);
    check_eq("b_meip", 64'(meip_b), 64'd1);
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd0, 3'd4, 1'b0, 4'd0);
    check_eq("b_rst_mtime", 64'(rd_b), 64'd0);
    check_eq("b_rst_meip", 64'(meip_b), 64'd0);

    // Random traffic
    ext = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      we  = ($urandom_range(0, 3) == 0);
      wa  = 3'($urandom_range(0, 7));
      ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) ext = 3'($urandom);
      drive(rst, we, wa, rand_data(wa), 3'($urandom_range(0, 7)), ext, ack,
            causes[$urandom_range(0, 4)]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
